// File: rtl/seq_tx.sv
// Serial frame transmitter: loads a frame over a valid/ready handshake, shifts it out MSB-first,
// and flags emitted-bit history matches of 101 / 110 with a saturating hit counter.
module seq_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [3:0]       load_len,
  output logic             w,
  output logic             w_valid,
  output logic             done,
  output logic             hit,
  output logic [7:0]       hit_count,
  output logic [1:0]       state_dbg
);

  // Handshake: a frame transfers on a rising edge where load_valid and load_ready are both 1;
  // load_ready is high only while idle, and load_valid is ignored whenever load_ready is low.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [3:0] LEN_MAX = 4'(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [1:0]         hist_q, hist_d;
  logic [1:0]         hist_n_q, hist_n_d;
  logic               load_ready_q, load_ready_d;
  logic               w_q, w_d;
  logic               w_valid_q, w_valid_d;
  logic               done_q, done_d;
  logic               hit_q, hit_d;
  logic [7:0]         hit_count_q, hit_count_d;

  logic               accept;
  logic [3:0]         len_eff;

  assign accept  = load_valid && load_ready_q;
  assign len_eff = (load_len > LEN_MAX) ? LEN_MAX : load_len;

  // State register; every output is a flop so there is no input-to-output path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      hist_q       <= '0;
      hist_n_q     <= '0;
      load_ready_q <= 1'b1;
      w_q          <= 1'b0;
      w_valid_q    <= 1'b0;
      done_q       <= 1'b0;
      hit_q        <= 1'b0;
      hit_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      hist_q       <= hist_d;
      hist_n_q     <= hist_n_d;
      load_ready_q <= load_ready_d;
      w_q          <= w_d;
      w_valid_q    <= w_valid_d;
      done_q       <= done_d;
      hit_q        <= hit_d;
      hit_count_q  <= hit_count_d;
    end
  end

  // Next-state: cnt_q holds the bits still to present, including the one currently on w.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shreg_d = load_data;
          cnt_d   = len_eff;
          state_d = (len_eff == 4'd0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state, so they line up with the state they describe.
  always_comb begin
    load_ready_d = (state_d == S_IDLE);
    w_valid_d    = (state_d == S_SHIFT);
    w_d          = w_valid_d & shreg_d[WIDTH-1];
    done_d       = (state_d == S_DONE);
    hist_d       = hist_q;
    hist_n_d     = hist_n_q;
    hit_d        = 1'b0;
    hit_count_d  = hit_count_q;
    if (w_valid_q) begin
      hit_d  = (hist_n_q == 2'd2) &&
               (({hist_q, w_q} == 3'b101) || ({hist_q, w_q} == 3'b110));
      hist_d = {hist_q[0], w_q};
      if (hist_n_q != 2'd2) begin
        hist_n_d = hist_n_q + 2'd1;
      end
    end
    if (hit_d && (hit_count_q != 8'hFF)) begin
      hit_count_d = hit_count_q + 8'd1;
    end
  end

  assign load_ready = load_ready_q;
  assign w          = w_q;
  assign w_valid    = w_valid_q;
  assign done       = done_q;
  assign hit        = hit_q;
  assign hit_count  = hit_count_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx: randomized frames scored against a bit-stream reference model.
module tb_seq_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic [3:0]   load_len;
  logic         w;
  logic         w_valid;
  logic         done;
  logic         hit;
  logic [7:0]   hit_count;
  logic [1:0]   state_dbg;

  seq_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .w          (w),
    .w_valid    (w_valid),
    .done       (done),
    .hit        (hit),
    .hit_count  (hit_count),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected stream: one entry per emitted bit, plus one entry per frame for done.
  logic [0:0] exp_q[$];
  logic [0:0] hit_q[$];
  logic [7:0] cnt_q[$];
  int         len_q[$];

  int         m_hist_n;
  logic [1:0] m_hist;
  int         m_hits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    hit_q.delete();
    cnt_q.delete();
    len_q.delete();
    m_hist_n = 0;
    m_hist   = 2'b00;
    m_hits   = 0;
  endfunction

  function automatic void model_frame(input logic [W-1:0] d, input logic [3:0] len);
    int n;
    n = (int'(len) > W) ? W : int'(len);
    for (int i = 0; i < n; i++) begin
      logic b;
      logic h;
      b = d[W-1-i];
      h = (m_hist_n >= 2) && (({m_hist, b} == 3'b101) || ({m_hist, b} == 3'b110));
      exp_q.push_back(b);
      hit_q.push_back(h);
      if (h) m_hits++;
      m_hist = {m_hist[0], b};
      if (m_hist_n < 2) m_hist_n++;
    end
    len_q.push_back(n);
    cnt_q.push_back((m_hits > 255) ? 8'd255 : 8'(m_hits));
  endfunction

  // Presents a frame and returns just after the edge that accepts it; load_valid stays high.
  task automatic issue(input logic [W-1:0] d, input logic [3:0] len);
    int t;
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = d;
    load_len   = len;
    t = 0;
    while (!load_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!load_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      load_valid = 1'b0;
    end else begin
      model_frame(d, len);
      @(posedge clk);
    end
  endtask

  task automatic release_load();
    #1;
    load_valid = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a bit, a hit slot or a done pulse.
  logic       hit_pending;
  int         bits_seen;
  logic [0:0] e_bit;
  logic [7:0] e_cnt;
  int         e_len;

  always @(negedge clk) begin
    if (!rst_n) begin
      hit_pending = 1'b0;
      bits_seen   = 0;
    end else begin
      if (hit_pending) begin
        if (hit_q.size() == 0) begin
          check("hit_unexpected_slot", 32'd1, 32'd0);
        end else begin
          e_bit = hit_q.pop_front();
          check("hit", hit, e_bit);
        end
      end else begin
        check("hit_idle", hit, 1'b0);
      end
      if (w_valid) begin
        if (exp_q.size() == 0) begin
          check("w_unexpected", 32'd1, 32'd0);
        end else begin
          e_bit = exp_q.pop_front();
          check("w_bit", w, e_bit);
        end
        bits_seen++;
      end else begin
        check("w_zero_when_invalid", w, 1'b0);
        if (!done) check("bit_gap", bits_seen, 0);
      end
      if (done) begin
        check("done_wvalid", w_valid, 1'b0);
        if (cnt_q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          e_cnt = cnt_q.pop_front();
          e_len = len_q.pop_front();
          check("hit_count_at_done", hit_count, e_cnt);
          check("frame_bits", bits_seen, e_len);
        end
        bits_seen = 0;
      end
      hit_pending = w_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] pat;
    int         t;
    rst_n      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_len   = '0;
    model_reset();

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_load_ready", load_ready, 1'b1);
    check("rst_w_valid", w_valid, 1'b0);
    check("rst_w", w, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hit", hit, 1'b0);
    check("rst_hit_count", hit_count, 8'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    repeat (5) @(negedge clk);
    check("idle_load_ready", load_ready, 1'b1);
    check("idle_w_valid", w_valid, 1'b0);
    check("idle_done", done, 1'b0);
    check("idle_hit_count", hit_count, 8'd0);

    // A0 len 3: bits 1,0,1 then done together with the first hit.
    issue(8'hA0, 4'd3);
    release_load();
    pat = 3'b101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("a0_w_valid", w_valid, 1'b1);
      check("a0_w", w, pat[2-i]);
      check("a0_load_ready", load_ready, 1'b0);
    end
    @(negedge clk);
    check("a0_done", done, 1'b1);
    check("a0_hit", hit, 1'b1);
    check("a0_hit_count", hit_count, 8'd1);

    // Zero-length frame: done next cycle, ready the cycle after.
    issue(8'h5A, 4'd0);
    release_load();
    @(negedge clk);
    check("len0_done", done, 1'b1);
    check("len0_w_valid", w_valid, 1'b0);
    check("len0_load_ready", load_ready, 1'b0);
    @(negedge clk);
    check("len0_ready_back", load_ready, 1'b1);
    check("len0_done_clear", done, 1'b0);

    // Over-long length clamps to WIDTH; load_valid held through the frame is ignored.
    issue(8'hFF, 4'd12);
    issue(8'h5A, 4'd4);
    release_load();

    // Randomized frames, sometimes back-to-back with load_valid held.
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] d;
      logic [3:0]   l;
      d = W'($urandom_range(0, 255));
      l = 4'($urandom_range(0, 15));
      issue(d, l);
      if ($urandom_range(0, 1) == 0) begin
        release_load();
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    end
    release_load();

    // Reset during the 4th bit of an 8-bit frame.
    issue(8'hC3, 4'd8);
    release_load();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_w_valid", w_valid, 1'b0);
    check("abort_w", w, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_hit", hit, 1'b0);
    check("abort_hit_count", hit_count, 8'd0);
    check("abort_load_ready", load_ready, 1'b1);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(8'h96, 4'd8);
    release_load();

    // Saturation of hit_count with repeated B6 frames.
    for (int k = 0; k < 60; k++) begin
      issue(8'hB6, 4'd8);
    end
    release_load();

    t = 0;
    while ((cnt_q.size() != 0 || exp_q.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", cnt_q.size(), 0);
    repeat (3) @(negedge clk);
    check("hit_count_saturated", hit_count, (m_hits > 255) ? 8'd255 : 8'(m_hits));
    check("final_load_ready", load_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
